// File: rtl/serial_pe_feeder.sv
// Sequencer that streams a neuron/weight vector pair into one serial MAC PE
// over its beat protocol and captures the PE's 32-bit dot-product result.
module serial_pe_feeder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic signed [15:0]  wr_data,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [31:0]         result,
  output logic signed [15:0]  pe_neuron,
  output logic signed [15:0]  pe_weight,
  output logic [1:0]          pe_ctl,
  output logic                pe_vld,
  input  logic [31:0]         pe_result,
  input  logic                pe_res_vld
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t             state, state_next;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  last_idx;

  logic signed [15:0] nbuf [DEPTH];
  logic signed [15:0] wbuf [DEPTH];

  logic [ADDR_W:0]    len_eff;
  logic [ADDR_W-1:0]  new_last;
  logic               start_feed;
  logic               start_zero;
  logic               issue;
  logic [ADDR_W-1:0]  issue_idx;
  logic               issue_last;

  // The start edge itself carries beat 0, so beats occupy the len cycles
  // immediately following the start edge.
  assign len_eff    = (len > DEPTH_L) ? DEPTH_L : len;
  assign new_last   = ADDR_W'(len_eff - 1'b1);
  assign start_feed = (state == S_IDLE) && start && (len != '0);
  assign start_zero = (state == S_IDLE) && start && (len == '0);
  assign issue      = start_feed || ((state == S_FEED) && !hold);
  assign issue_idx  = start_feed ? '0 : idx;
  assign issue_last = (issue_idx == (start_feed ? new_last : last_idx));

  // NOTE: buffer storage has no reset; contents deliberately survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (wr_sel) wbuf[wr_addr] <= wr_data;
      else        nbuf[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;  // NOTE: default first so no path infers a latch.
    case (state)
      S_IDLE: if (start) begin
        if (len == '0)      state_next = S_DONE;
        else if (issue_last) state_next = S_WAIT;
        else                 state_next = S_FEED;
      end
      S_FEED: if (issue && issue_last) state_next = S_WAIT;
      S_WAIT: if (pe_res_vld) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      last_idx  <= '0;
      pe_neuron <= '0;
      pe_weight <= '0;
      pe_ctl    <= '0;
      pe_vld    <= 1'b0;
      result    <= '0;
    end else begin
      if (start_feed) last_idx <= new_last;
      if (issue) begin
        pe_neuron <= nbuf[issue_idx];
        pe_weight <= wbuf[issue_idx];
        pe_vld    <= 1'b1;
        pe_ctl    <= {issue_last, issue_idx == '0};
        idx       <= issue_idx + 1'b1;
      end else begin
        // Operands keep their last values through bubbles and WAIT.
        pe_vld <= 1'b0;
        pe_ctl <= '0;
      end
      if (start_zero)                          result <= '0;
      else if ((state == S_WAIT) && pe_res_vld) result <= pe_result;
    end
  end

endmodule

// File: tb/tb_serial_pe_feeder.sv
// Directed bench for serial_pe_feeder with a behavioural serial MAC PE.
// Cycle c=1 is the cycle right after the edge that samples start.
module tb_serial_pe_feeder;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic               wr_sel = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic signed [15:0] wr_data = '0;
  logic               start = 1'b0;
  logic [ADDR_W:0]    len = '0;
  logic               hold = 1'b0;
  logic               busy, done;
  logic [31:0]        result;
  logic signed [15:0] pe_neuron, pe_weight;
  logic [1:0]         pe_ctl;
  logic               pe_vld;
  logic [31:0]        pe_result;
  logic               pe_res_vld;

  logic signed [31:0] acc, model_res, n_ext, w_ext, model_sum;
  logic               model_vld;
  logic               spur = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pe_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .len(len), .hold(hold), .busy(busy),
    .done(done), .result(result), .pe_neuron(pe_neuron), .pe_weight(pe_weight),
    .pe_ctl(pe_ctl), .pe_vld(pe_vld), .pe_result(pe_result), .pe_res_vld(pe_res_vld)
  );

  // Behavioural PE: clears on ctl[0], emits on ctl[1] with result valid next cycle.
  assign n_ext      = pe_neuron;
  assign w_ext      = pe_weight;
  assign model_sum  = (pe_ctl[0] ? 32'sd0 : acc) + n_ext * w_ext;
  assign pe_res_vld = model_vld | spur;
  assign pe_result  = spur ? 32'hDEAD_BEEF : model_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      model_res <= '0;
      model_vld <= 1'b0;
    end else begin
      model_vld <= 1'b0;
      if (pe_vld) begin
        acc <= model_sum;
        if (pe_ctl[1]) begin
          model_res <= model_sum;
          model_vld <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [ADDR_W-1:0] addr, input logic signed [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, ADDR_W'(i), 16'(i + 1));
      wr(1'b1, ADDR_W'(i), 16'(i + 5));
    end
  endtask

  task automatic do_start(input logic [ADDR_W:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes cycles c=1..budget (bounded), applying hold_map[c] before edge T+c.
  task automatic watch(input int budget, input logic [127:0] hold_map, input bit meddle,
                       output int n_beats, output int done_at, output logic [15:0] ctl_seq,
                       output logic [15:0] vld_map, output logic [31:0] prod_sum,
                       output logic [31:0] op_snap);
    logic signed [31:0] a, b;
    n_beats = 0; done_at = 0; ctl_seq = '0; vld_map = '0; prod_sum = '0; op_snap = '0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      hold = hold_map[c];
      if (meddle && c == 2) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 16'sd100;
        start = 1'b1; len = 7'd1;
      end
      if (meddle && c == 3) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (pe_vld) begin
        n_beats++;
        ctl_seq = {ctl_seq[13:0], pe_ctl};
        a = pe_neuron; b = pe_weight;
        prod_sum += a * b;
      end
      if (c <= 16) vld_map[c-1] = pe_vld;
      if (c == 3) op_snap = {pe_neuron, pe_weight};
      if (done) begin
        done_at = c;
        break;
      end
    end
    hold = 1'b0;
  endtask

  int          n, d;
  logic [15:0] cs, vm;
  logic [31:0] ps, os;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vld", pe_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ctl", pe_ctl, 0);
    check("rst_ops", {pe_neuron, pe_weight}, 0);

    // Basic dot product: 1*5+2*6+3*7+4*8 = 70.
    load_basic();
    do_start(7'd4);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("basic_beats", n, 4);
    check("basic_ctl", cs, 16'h0042);
    check("basic_vld_map", vm, 16'h000F);
    check("basic_ops", ps, 70);
    check("basic_done_at", d, 6);
    check("basic_result", result, 70);
    @(negedge clk);
    check("basic_done_pulse", done, 0);
    check("basic_busy_end", busy, 0);

    // Bubbles after the second beat.
    do_start(7'd4);
    watch(20, 128'b1100, 1'b0, n, d, cs, vm, ps, os);
    check("bub_vld_map", vm, 16'h0033);
    check("bub_op_hold", os, 32'h0002_0006);
    check("bub_ctl", cs, 16'h0042);
    check("bub_done_at", d, 8);
    check("bub_result", result, 70);
    @(negedge clk);

    // Single element: -5 * 3.
    wr(1'b0, 0, -16'sd5);
    wr(1'b1, 0, 16'sd3);
    do_start(7'd1);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("one_beats", n, 1);
    check("one_ctl", cs, 16'h0003);
    check("one_done_at", d, 3);
    check("one_result", result, 32'hFFFF_FFF1);
    @(negedge clk);

    // Overflow wrap: 4 * 2^30 wraps to 0.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, ADDR_W'(i), -16'sd32768);
      wr(1'b1, ADDR_W'(i), -16'sd32768);
    end
    do_start(7'd4);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("ovf_done_at", d, 6);
    check("ovf_result", result, 32'h0000_0000);
    @(negedge clk);

    // Start and writes while busy are dropped.
    load_basic();
    do_start(7'd4);
    watch(20, '0, 1'b1, n, d, cs, vm, ps, os);
    check("busy_beats", n, 4);
    check("busy_done_at", d, 6);
    check("busy_result", result, 70);
    @(negedge clk);
    check("busy_no_restart", busy, 0);
    do_start(7'd4);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("busy_buf_kept", result, 70);
    @(negedge clk);

    // len=0 forces a zero result with no beats.
    do_start(7'd0);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("zero_done_at", d, 1);
    check("zero_beats", n, 0);
    check("zero_result", result, 0);
    @(negedge clk);

    // len above DEPTH clamps to DEPTH beats.
    do_start(7'd100);
    watch(80, '0, 1'b0, n, d, cs, vm, ps, os);
    check("clamp_beats", n, DEPTH);
    check("clamp_done_at", d, DEPTH + 2);
    @(negedge clk);

    // Result valid outside WAIT is ignored.
    do_start(7'd4);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_result", result, 70);
    check("spur_done", done, 0);

    // Asynchronous reset during the second beat, then a fresh run.
    do_start(7'd4);
    @(negedge clk);
    check("rstmid_beat2", {15'd0, pe_vld, pe_neuron}, 32'h0001_0002);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_result", result, 0);
    check("rstmid_vld_ctl", {pe_vld, pe_ctl}, 0);
    check("rstmid_ops", {pe_neuron, pe_weight}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(7'd4);
    watch(20, '0, 1'b0, n, d, cs, vm, ps, os);
    check("rstmid_rerun_done_at", d, 6);
    check("rstmid_rerun_result", result, 70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pe_feeder.md
# serial_pe_feeder

Sequencer that drives one serial_pe-style multiply-accumulate PE over its beat protocol (neuron, weight, ctl, valid) and collects the PE's result. It holds a neuron vector and a weight vector in local register-file buffers loaded through a write port. On `start` it streams `len` beats with the first/last flags encoded in `ctl`, waits for the PE's result valid, then latches the 32-bit result and pulses `done`. It sits between the layer controller and each serial PE.

## Interface
- `DEPTH`, default 64: entries per buffer (neuron and weight); power of two.
- `ADDR_W`, default 6: log2(DEPTH).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: buffer write strobe.
- `wr_sel` in 1: buffer select; 0 = neuron buffer, 1 = weight buffer.
- `wr_addr` in ADDR_W: buffer write address.
- `wr_data` in 16: signed write data.
- `start` in 1: start a dot product; sampled only in IDLE.
- `len` in ADDR_W+1: element count, sampled with `start`; values above DEPTH are clamped to DEPTH.
- `hold` in 1: inserts a bubble; while high in FEED, the next cycle carries no beat.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out 32: last captured PE result; holds until the next capture.
- `pe_neuron` out 16: signed neuron operand to the PE.
- `pe_weight` out 16: signed weight operand to the PE.
- `pe_ctl` out 2: bit0 = first beat (PE clears its accumulator); bit1 = last beat (PE emits its result).
- `pe_vld` out 1: beat valid to the PE.
- `pe_result` in 32: PE accumulator output.
- `pe_res_vld` in 1: PE result valid; high the cycle after the PE accepts the last beat.

## Operation
- Buffers: 2×DEPTH×16-bit flops with combinational read. The buffers are not reset and their contents survive `rst_n`.
  - A write lands at the clock edge when `wr_en`=1 and `busy`=0.
  - Writes while `busy`=1 are dropped.
- States: IDLE, FEED, WAIT, DONE.
- IDLE:
  - `start`=1 with `len`≥1: latch `len`, clear index `idx` to 0, go to FEED.
  - `start`=1 with `len`=0: go to DONE and force the captured value to 0 (no beats are issued).
- FEED, at each edge:
  - `hold`=0: register `pe_neuron`=nbuf[idx], `pe_weight`=wbuf[idx], `pe_vld`=1, `pe_ctl[0]`=(idx==0), `pe_ctl[1]`=(idx==len-1), then idx++.
  - `hold`=1: `pe_vld`=0, `pe_ctl`=0, operands hold their previous values, idx is unchanged.
  - After the last beat is registered, go to WAIT.
- WAIT:
  - `pe_vld`=0 and `pe_ctl`=0.
  - On `pe_res_vld`=1, capture `pe_result` into `result` and go to DONE.
  - `hold` is ignored.
- DONE: `done`=1 for this single cycle, then return to IDLE.
- `len`=1: the single beat carries `pe_ctl`=2'b11.
- `pe_res_vld` outside WAIT is ignored; `result` does not change.
- `start` while `busy`=1 is ignored. A new start is accepted in the IDLE cycle after DONE, with no back-to-back overlap.
- Arithmetic: the feeder does no math. It passes the PE's 32-bit two's-complement result through unchanged, so overflow wraps modulo 2^32 as produced by the PE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `pe_neuron`=0, `pe_weight`=0, `pe_ctl`=0, `pe_vld`=0, idx=0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronously); the transfer is abandoned.
- With `start` sampled at edge T and no holds:
  - beats are driven in cycles T+1 … T+len;
  - `pe_res_vld` arrives in cycle T+len+1;
  - `result` and `done` are valid in cycle T+len+2;
  - `busy` is high from T+1 through T+len+2.
- Each `hold`=1 edge during FEED delays the remaining beats, `pe_res_vld`, and `done` by one cycle.
- `len`=0: `done` is high in T+1 with `result`=0.

## Test plan
- **Basic dot product.** Load neurons 1,2,3,4 and weights 5,6,7,8, then `start` with `len`=4, no hold.
  - Beats appear in T+1..T+4 with `pe_ctl` = 01, 00, 00, 10.
  - `done` in T+6 with `result`=70.
- **Single element.** `len`=1 with neuron −5 and weight 3.
  - One beat with `pe_ctl`=11.
  - `result`=0xFFFFFFF1; `done` in T+3.
- **Bubbles.** The basic dot product with `hold`=1 for two edges after the second beat.
  - `pe_vld` is low for 2 cycles mid-stream.
  - `result`=70; `done` in T+8.
- **Overflow wrap.** Four elements, each neuron and weight = −32768.
  - `result`=0x00000000 (sum of 4×2^30 wraps modulo 2^32).
- **Edge cases.**
  - `len`=0: `done` in T+1 with `result`=0 and no `pe_vld`.
  - `start` and buffer writes while busy: ignored. The running result is unchanged and the buffers are unchanged after completion.
- **Reset mid-FEED.** Assert `rst_n`=0 during beat 2.
  - All outputs return to reset values.
  - A fresh `start` afterwards returns 70 using the retained buffer contents.
